udp_chain_node: RTL and testbench
=================================

// Module: udp_chain_node
// PURPOSE
//  One node of a daisy-chained UDP outbound command stream.
//  - Parses each received packet and extracts the payload of the submessage addressed to this node.
//  - The address selected is the packet's hop count.
//  - Retransmits the packet downstream with hop count +1, so the next node selects the next submessage.
//  - Sits between the UDP payload receiver and the downstream chain link.
// PARAMETERS
//  PROTO_ID  16'h0001  protocol word that enables extraction and hop increment
// PORTS
//  c              in   1   system clock (single clock domain)
//  rst_n          in   1   reset, asynchronous assert, active-low
//  rxd            in   8   received packet byte
//  rxdv           in   1   rxd valid; high for the whole packet, low ends the packet
//  rxlast         in   1   1-cycle end-of-packet strobe; may arrive many cycles after rxdv falls
//  txd            out  8   retransmitted byte
//  txdv           out  1   txd valid
//  hop_count      out  16  hop count of the last received packet
//  submsg_rxd     out  8   payload byte of the matching submessage
//  submsg_rxdv    out  1   submsg_rxd valid
//  submsg_rxlast  out  1   1-cycle end strobe for the extracted submessage
// BEHAVIOUR
//  Packet format (all 16-bit fields little-endian):
//  - bytes 0-1: protocol; bytes 2-3: hop count.
//  - then repeated {addr[2], len[2], payload[len]} until rxdv falls.
//  Reset: all outputs 0; parser in PROTO0; carry and match flags cleared.
//  Parser FSM (advances only on rxdv=1; any cycle with rxdv=0 forces PROTO0):
//  - PROTO0 -> PROTO1 -> HOP0 -> HOP1 -> ADDR0 -> ADDR1 -> LEN0 -> LEN1 -> PAYLOAD.
//  - LEN1 with len==0 goes to ADDR0; otherwise PAYLOAD counts len bytes, then ADDR0.
//  - PROTO1 with protocol != PROTO_ID goes to DISCARD, which holds until rxdv=0.
//  hop_count: registered at HOP1 (cycle after byte 3); holds until the next valid packet.
//  - Not updated by mismatched-protocol packets.
//  Extraction:
//  - In PAYLOAD, if addr == hop_count, submsg_rxd/submsg_rxdv = rxd/1, one cycle later.
//  - Header bytes are never emitted.
//  - Multiple submessages with the same addr are all emitted.
//  - submsg_rxlast: pulses 1 cycle after rxlast, only if at least one payload byte was emitted since the previous rxlast.
//  - The emitted-flag clears when submsg_rxlast pulses.
//  - rxlast with no match produces no pulse.
//  Truncation: if rxdv falls mid-header or mid-payload, the fragment is dropped silently.
//  - Bytes already emitted are kept.
//  - The next packet parses from PROTO0.
//  TX path: fixed latency of 1 cycle; txdv = rxdv delayed 1.
//  - txd = rxd delayed 1, except when protocol matches:
//  - byte 2 out = rxd+1 (mod 256); carry = (rxd==8'hFF).
//  - byte 3 out = rxd+carry (mod 256), so 16'hFFFF wraps to 16'h0000.
//  - Non-matching protocol is forwarded byte-exact.
//  - A packet shorter than 4 bytes is forwarded unmodified as far as it goes.
//  Back-to-back packets need at least 1 idle cycle (rxdv=0) between them.
// CONFIGURATION
//  UDP_CHAIN_HOP_SAT_EN defined: a hop count of 16'hFFFF is retransmitted as 16'hFFFF (saturating).
//  - Undefined: the hop count wraps to 16'h0000.
//  - Extraction is unaffected either way.
// STRUCTURE
//  Package udp_chain_pkg: parser state enum; byte offsets (PROTO=0, HOP=2, SUB_HDR=4 bytes); PROTO_ID default.
//  Sub-module udp_chain_hop_rewriter: the TX byte counter and hop increment (1-cycle pipeline).
//  - Parser, extraction and hop_count register live in the top level.
// TESTING
//  1. Send 01 00 00 00 | 00 00 02 00 12 34 | 01 00 02 00 56 78 | 02 00 04 00 AB CD EF 42, then rxlast after 20 idle cycles.
//     -> hop_count=0; submsg=12,34; submsg_rxlast 1 cycle after rxlast.
//     -> txd equals the input except byte 2=01.
//  2. Chain three nodes on the stimulus of test 1.
//     -> node2 submsg=56,78 with hop_count=1; node3 submsg=AB,CD,EF,42 with hop_count=2.
//     -> node3 txd byte 2=03.
//  3. Protocol 02 00, same body.
//     -> no submsg_rxdv and no submsg_rxlast; txd identical to rxd with 1-cycle delay.
//     -> hop_count unchanged.
//  4. Hop bytes FF 00 -> tx hop bytes 00 01.
//     -> Hop bytes FF FF -> 00 00, or FF FF with UDP_CHAIN_HOP_SAT_EN.
//  5. Zero-length submessage addr 0 followed by addr 0 len 1 payload 99 -> submsg=99 only.
//     -> Drop rxdv mid-payload: remaining bytes absent, next packet parsed correctly.
//  6. Assert rst_n=0 mid-packet -> all outputs 0 immediately.
//     -> After release, the next packet is extracted correctly.

Source files
------------

// File: rtl/udp_chain_pkg.sv
// Shared types and constants for the UDP daisy-chain node.
package udp_chain_pkg;

   typedef enum logic [3:0] {
      S_PROTO0, S_PROTO1, S_HOP0, S_HOP1,
      S_ADDR0, S_ADDR1, S_LEN0, S_LEN1,
      S_PAYLOAD, S_DISCARD
   } state_e;

   localparam int PROTO_OFS = 0;
   localparam int HOP_OFS   = 2;
   localparam int SUB_HDR   = 4;

   localparam logic [15:0] PROTO_ID_DEF = 16'h0001;

endpackage

// File: rtl/udp_chain_hop_rewriter.sv
// TX path: 1-cycle pipeline that increments the hop count of matching packets.
// UDP_CHAIN_HOP_SAT_EN: hop 16'hFFFF is retransmitted unchanged instead of wrapping.
module udp_chain_hop_rewriter
   import udp_chain_pkg::*;
(
   input  logic       c_i,
   input  logic       rst_ni,
   input  logic [7:0] rxd_i,
   input  logic       rxdv_i,
   input  logic       proto_ok_i,
   output logic [7:0] txd_o,
   output logic       txdv_o
);

   logic [2:0] cnt_q, cnt_d;
   logic [7:0] txd_q, txd_d;
   logic       txdv_q;
   logic       slot2_q, slot2_d;
   logic       carry_q, carry_d;
   logic       b2, b3;
   logic [7:0] hop_lo;

   assign b2 = rxdv_i && proto_ok_i && (cnt_q == 3'(HOP_OFS));
   assign b3 = rxdv_i && proto_ok_i && (cnt_q == 3'(HOP_OFS + 1));

   always_comb begin
      cnt_d   = cnt_q;
      slot2_d = b2;
      carry_d = carry_q;
      txd_d   = rxd_i;
      if (!rxdv_i)
         cnt_d = 3'(PROTO_OFS);
      else if (cnt_q != 3'(SUB_HDR))
         cnt_d = cnt_q + 3'd1;
      if (b2)
         carry_d = (rxd_i == 8'hFF);
      if (b3) begin
`ifdef UDP_CHAIN_HOP_SAT_EN
         if (carry_q && rxd_i == 8'hFF)
            txd_d = 8'hFF;
         else
            txd_d = rxd_i + {7'd0, carry_q};
`else
         txd_d = rxd_i + {7'd0, carry_q};
`endif
      end
   end

   // Low hop byte is resolved on the way out: only a packet that
   // reaches byte 3 is modified, and saturation needs byte 3 too.
   always_comb begin
      hop_lo = txd_q;
      if (slot2_q && rxdv_i) begin
         hop_lo = txd_q + 8'd1;
`ifdef UDP_CHAIN_HOP_SAT_EN
         if (txd_q == 8'hFF && rxd_i == 8'hFF)
            hop_lo = 8'hFF;
`endif
      end
   end

   always_ff @(posedge c_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         txd_q   <= '0;
         txdv_q  <= 1'b0;
         slot2_q <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         txdv_q  <= rxdv_i;
         slot2_q <= slot2_d;
         carry_q <= carry_d;
      end
   end

   assign txd_o  = hop_lo;
   assign txdv_o = txdv_q;

endmodule

// File: rtl/udp_chain_node.sv
// Daisy-chain node: extracts the submessage addressed by the hop count.
// UDP_CHAIN_HOP_SAT_EN selects saturating hop increment in the TX path.
module udp_chain_node
   import udp_chain_pkg::*;
#(
   parameter logic [15:0] PROTO_ID = PROTO_ID_DEF
) (
   input  logic        c,
   input  logic        rst_n,
   input  logic [7:0]  rxd,
   input  logic        rxdv,
   input  logic        rxlast,
   output logic [7:0]  txd,
   output logic        txdv,
   output logic [15:0] hop_count,
   output logic [7:0]  submsg_rxd,
   output logic        submsg_rxdv,
   output logic        submsg_rxlast
);

   state_e      state_q, state_d;
   logic [7:0]  lo_q, lo_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] hop_q, hop_d;
   logic        match_q, match_d;
   logic        emit_q, emit_d;
   logic        sdv_q, slast_q, slast_d;
   logic [7:0]  sd_q, sd_d;
   logic        emit;
   logic        proto_ok;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      hop_d   = hop_q;
      match_d = match_q;
      emit    = 1'b0;
      if (!rxdv) begin
         state_d = S_PROTO0;
      end else begin
         unique case (state_q)
            S_PROTO0: begin
               lo_d    = rxd;
               state_d = S_PROTO1;
            end
            S_PROTO1: state_d = ({rxd, lo_q} == PROTO_ID) ? S_HOP0 : S_DISCARD;
            S_HOP0: begin
               lo_d    = rxd;
               state_d = S_HOP1;
            end
            S_HOP1: begin
               hop_d   = {rxd, lo_q};
               state_d = S_ADDR0;
            end
            S_ADDR0: begin
               lo_d    = rxd;
               state_d = S_ADDR1;
            end
            S_ADDR1: begin
               match_d = ({rxd, lo_q} == hop_q);
               state_d = S_LEN0;
            end
            S_LEN0: begin
               lo_d    = rxd;
               state_d = S_LEN1;
            end
            S_LEN1: begin
               cnt_d   = {rxd, lo_q};
               state_d = (cnt_d == 16'd0) ? S_ADDR0 : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               emit  = match_q;
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1)
                  state_d = S_ADDR0;
            end
            S_DISCARD: state_d = S_DISCARD;
            default:   state_d = S_PROTO0;
         endcase
      end
   end

   // Emitted flag spans rxlast gaps so a late rxlast still closes the submessage.
   always_comb begin
      sd_d    = emit ? rxd : 8'd0;
      slast_d = rxlast && (emit_q || emit);
      emit_d  = rxlast ? 1'b0 : (emit_q || emit);
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_PROTO0;
         lo_q    <= '0;
         cnt_q   <= '0;
         hop_q   <= '0;
         match_q <= 1'b0;
         emit_q  <= 1'b0;
         sd_q    <= '0;
         sdv_q   <= 1'b0;
         slast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         hop_q   <= hop_d;
         match_q <= match_d;
         emit_q  <= emit_d;
         sd_q    <= sd_d;
         sdv_q   <= emit;
         slast_q <= slast_d;
      end
   end

   assign proto_ok = (state_q == S_HOP0) || (state_q == S_HOP1);

   udp_chain_hop_rewriter u_hop (
      .c_i        (c),
      .rst_ni     (rst_n),
      .rxd_i      (rxd),
      .rxdv_i     (rxdv),
      .proto_ok_i (proto_ok),
      .txd_o      (txd),
      .txdv_o     (txdv)
   );

   assign hop_count     = hop_q;
   assign submsg_rxd    = sd_q;
   assign submsg_rxdv   = sdv_q;
   assign submsg_rxlast = slast_q;

endmodule

// File: tb/tb_udp_chain_node.sv
// Directed bench for udp_chain_node: vector table plus chain and reset sequences.
module tb_udp_chain_node;

   typedef struct {
      int          off;
      int          len;
      logic [63:0] sub;
      int          nsub;
      logic [15:0] hc;
      bit          mdf;
      logic [15:0] txhop;
      bit          pulse;
   } vec_t;

`ifdef UDP_CHAIN_HOP_SAT_EN
   localparam logic [15:0] WRAP_HOP = 16'hFFFF;
`else
   localparam logic [15:0] WRAP_HOP = 16'h0000;
`endif

   logic        c = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rxd = '0;
   logic        rxdv = 1'b0;
   logic        rxlast = 1'b0;
   logic [7:0]  txd1, txd2, txd3, sd1, sd2, sd3;
   logic        txdv1, txdv2, txdv3, sv1, sv2, sv3, sl1, sl2, sl3;
   logic [15:0] hc1, hc2, hc3;

   always #5 c = ~c;

   udp_chain_node u1 (
      .c(c), .rst_n(rst_n), .rxd(rxd), .rxdv(rxdv), .rxlast(rxlast),
      .txd(txd1), .txdv(txdv1), .hop_count(hc1),
      .submsg_rxd(sd1), .submsg_rxdv(sv1), .submsg_rxlast(sl1));
   udp_chain_node u2 (
      .c(c), .rst_n(rst_n), .rxd(txd1), .rxdv(txdv1), .rxlast(rxlast),
      .txd(txd2), .txdv(txdv2), .hop_count(hc2),
      .submsg_rxd(sd2), .submsg_rxdv(sv2), .submsg_rxlast(sl2));
   udp_chain_node u3 (
      .c(c), .rst_n(rst_n), .rxd(txd2), .rxdv(txdv2), .rxlast(rxlast),
      .txd(txd3), .txdv(txdv3), .hop_count(hc3),
      .submsg_rxd(sd3), .submsg_rxdv(sv3), .submsg_rxlast(sl3));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lcyc, pcyc, npulse;
   logic [7:0] tx1q[$], tx3q[$], s1q[$], s2q[$], s3q[$];
   logic [7:0] pool[$];
   vec_t v[$];

   always @(posedge c) cyc++;

   always @(negedge c) begin
      if (rst_n) begin
         if (txdv1) tx1q.push_back(txd1);
         if (txdv3) tx3q.push_back(txd3);
         if (sv1) s1q.push_back(sd1);
         if (sv2) s2q.push_back(sd2);
         if (sv3) s3q.push_back(sd3);
         if (rxlast) lcyc = cyc;
         if (sl1) begin
            npulse++;
            pcyc = cyc;
         end
      end
   end

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic chkq(input string n, input logic [7:0] a[$], input logic [7:0] e[$]);
      bit ok;
      ok = (a.size() == e.size());
      if (ok) foreach (e[k]) if (a[k] !== e[k]) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d bytes %p expected %0d bytes %p",
                  n, a.size(), a, e.size(), e);
      end
   endtask

   task automatic add(input logic [7:0] b[$], input logic [63:0] sub, input int nsub,
                      input logic [15:0] hc, input bit mdf, input logic [15:0] txhop,
                      input bit pulse);
      vec_t r;
      r.off = pool.size();
      r.len = b.size();
      foreach (b[k]) pool.push_back(b[k]);
      r.sub = sub; r.nsub = nsub; r.hc = hc;
      r.mdf = mdf; r.txhop = txhop; r.pulse = pulse;
      v.push_back(r);
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge c);
         #1;
      end
   endtask

   task automatic send(input int off, input int len);
      for (int k = 0; k < len; k++) begin
         rxdv = 1'b1;
         rxd  = pool[off+k];
         tick(1);
      end
      rxdv = 1'b0;
      rxd  = '0;
   endtask

   task automatic close_pkt();
      tick(20);
      rxlast = 1'b1;
      tick(1);
      rxlast = 1'b0;
      tick(3);
   endtask

   task automatic clearq();
      tx1q = {}; tx3q = {}; s1q = {}; s2q = {}; s3q = {};
      npulse = 0; lcyc = -1; pcyc = -1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] e[$];
      int base;

      q = '{8'h01,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h02,8'h00,8'h12,8'h34,
            8'h01,8'h00,8'h02,8'h00,8'h56,8'h78,
            8'h02,8'h00,8'h04,8'h00,8'hAB,8'hCD,8'hEF,8'h42};
      add(q, 64'h3412, 2, 16'h0000, 1, 16'h0001, 1);
      q[0] = 8'h02; q[2] = 8'h05;
      add(q, 64'h0, 0, 16'h0000, 0, 16'h0, 0);
      q = '{8'h01,8'h00,8'hFF,8'h00, 8'hFF,8'h00,8'h01,8'h00,8'h77};
      add(q, 64'h77, 1, 16'h00FF, 1, 16'h0100, 1);
      q = '{8'h01,8'h00,8'hFF,8'hFF, 8'hFF,8'hFF,8'h01,8'h00,8'h88};
      add(q, 64'h88, 1, 16'hFFFF, 1, WRAP_HOP, 1);
      q = '{8'h01,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00,
            8'h00,8'h00,8'h01,8'h00,8'h99};
      add(q, 64'h99, 1, 16'h0000, 1, 16'h0001, 1);
      q = '{8'h01,8'h00,8'h01,8'h00, 8'h01,8'h00,8'h01,8'h00,8'hA1,
            8'h00,8'h00,8'h01,8'h00,8'hB0, 8'h01,8'h00,8'h02,8'h00,8'hA2,8'hA3};
      add(q, 64'hA3A2A1, 3, 16'h0001, 1, 16'h0002, 1);
      q = '{8'h01,8'h00,8'h07};
      add(q, 64'h0, 0, 16'h0001, 0, 16'h0, 0);
      q = '{8'h01,8'h00,8'h02,8'h00, 8'h02,8'h00,8'h04,8'h00,8'hC1,8'hC2};
      add(q, 64'hC2C1, 2, 16'h0002, 1, 16'h0003, 1);
      q = '{8'h01,8'h00,8'h02,8'h00, 8'h02,8'h00,8'h01,8'h00,8'hD5};
      add(q, 64'hD5, 1, 16'h0002, 1, 16'h0003, 1);

      tick(3);
      chk("reset_outs", {txd1, txdv1, hc1, sd1, sv1, sl1}, 64'h0);
      rst_n = 1'b1;
      tick(2);

      foreach (v[i]) begin
         clearq();
         send(v[i].off, v[i].len);
         close_pkt();
         e = {};
         for (int k = 0; k < v[i].len; k++) e.push_back(pool[v[i].off+k]);
         if (v[i].mdf) begin
            e[2] = v[i].txhop[7:0];
            e[3] = v[i].txhop[15:8];
         end
         chkq($sformatf("v%0d_tx", i), tx1q, e);
         e = {};
         for (int k = 0; k < v[i].nsub; k++) e.push_back(v[i].sub[8*k +: 8]);
         chkq($sformatf("v%0d_sub", i), s1q, e);
         chk($sformatf("v%0d_hop", i), 64'(hc1), 64'(v[i].hc));
         chk($sformatf("v%0d_npulse", i), 64'(npulse), 64'(v[i].pulse));
         if (v[i].pulse)
            chk($sformatf("v%0d_pulse_lat", i), 64'(pcyc - lcyc), 64'd1);
         if (i == 0) begin
            e = '{8'h56, 8'h78};
            chkq("node2_sub", s2q, e);
            chk("node2_hop", 64'(hc2), 64'd1);
            e = '{8'hAB, 8'hCD, 8'hEF, 8'h42};
            chkq("node3_sub", s3q, e);
            chk("node3_hop", 64'(hc3), 64'd2);
            e = {};
            for (int k = 0; k < v[0].len; k++) e.push_back(pool[v[0].off+k]);
            e[2] = 8'h03;
            chkq("node3_tx", tx3q, e);
         end
      end

      clearq();
      q = '{8'h01,8'h00,8'h05,8'h00, 8'h05,8'h00,8'h03,8'h00,8'hE1};
      base = pool.size();
      foreach (q[k]) pool.push_back(q[k]);
      for (int k = 0; k < 9; k++) begin
         rxdv = 1'b1;
         rxd  = pool[base+k];
         tick(1);
      end
      chk("pre_rst_hop", 64'(hc1), 64'h5);
      chk("pre_rst_sub", {sv1, sd1}, {1'b1, 8'hE1});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {txd1, txdv1, hc1, sd1, sv1, sl1}, 64'h0);
      rxdv = 1'b0;
      rxd  = '0;
      tick(2);
      rst_n = 1'b1;
      tick(2);

      clearq();
      q = '{8'h01,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h01,8'h00,8'h5A};
      base = pool.size();
      foreach (q[k]) pool.push_back(q[k]);
      send(base, q.size());
      close_pkt();
      e = '{8'h5A};
      chkq("post_rst_sub", s1q, e);
      chk("post_rst_hop", 64'(hc1), 64'h0);
      chk("post_rst_npulse", 64'(npulse), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
